// File: rtl/arp_pkg.sv
// Shared ARP/Ethernet constants, field offsets and the fixed-header byte helper.
// Pure definitions: no state, no latency, no flow control.
package arp_pkg;

  localparam logic [15:0] ETHERTYPE_ARP = 16'h0806;
  localparam logic [15:0] HTYPE_ETH     = 16'h0001;
  localparam logic [15:0] PTYPE_IPV4    = 16'h0800;
  localparam logic [7:0]  HLEN_ETH      = 8'h06;
  localparam logic [7:0]  PLEN_IPV4     = 8'h04;
  localparam logic [15:0] OPER_REQ      = 16'h0001;
  localparam logic [15:0] OPER_REP      = 16'h0002;

  localparam int OFF_DST  = 0;
  localparam int OFF_SRC  = 6;
  localparam int OFF_TYPE = 12;
  localparam int OFF_OPER = 20;
  localparam int OFF_SHA  = 22;
  localparam int OFF_SPA  = 28;
  localparam int OFF_THA  = 32;
  localparam int OFF_TPA  = 38;

  typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

  // Bytes OFF_TYPE..OFF_OPER+1 are identical for request and reply except the opcode.
  function automatic logic [7:0] hdr_byte(input logic [5:0] i, input logic [15:0] oper);
    logic [79:0] hdr;
    hdr      = {ETHERTYPE_ARP, HTYPE_ETH, PTYPE_IPV4, HLEN_ETH, PLEN_IPV4, oper};
    hdr_byte = 8'h00;
    for (int k = 0; k < 10; k++) begin
      if (i == 6'(OFF_TYPE + k)) hdr_byte = hdr[79-8*k -: 8];
    end
  endfunction

endpackage

// File: rtl/arp_responder_if.sv
// RX byte stream (no tready) and TX AXI-Stream reply port of one ARP responder.
// Signals only; the slave modport is the responder's view.
interface arp_responder_if;
  logic [7:0] rx_tdata;
  logic       rx_tvalid;
  logic       rx_tlast;
  logic [7:0] tx_tdata;
  logic       tx_tvalid;
  logic       tx_tlast;
  logic       tx_tready;

  modport master (output rx_tdata, rx_tvalid, rx_tlast, tx_tready,
                  input  tx_tdata, tx_tvalid, tx_tlast);
  modport slave  (input  rx_tdata, rx_tvalid, rx_tlast, tx_tready,
                  output tx_tdata, tx_tvalid, tx_tlast);
endinterface

// File: rtl/arp_rx_parser.sv
// Checks each RX byte against an ARP request for us; req_valid pulses combinationally on the tlast byte.
// No backpressure: every valid byte is consumed; idx advances only on valid bytes.
module arp_rx_parser
  import arp_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] my_ip,
  input  logic [47:0] my_mac,
  input  logic [7:0]  rx_tdata,
  input  logic        rx_tvalid,
  input  logic        rx_tlast,
  output logic        req_valid,
  output logic [47:0] req_sha,
  output logic [31:0] req_spa
);

  logic [5:0]  idx_q, idx_d;
  logic        bad_q, bad_d;
  logic        bc_bad_q, bc_bad_d;
  logic        uc_bad_q, uc_bad_d;
  logic [47:0] sha_q, sha_d;
  logic [31:0] spa_q, spa_d;
  logic        mism, bc_fail, uc_fail, bad_now;

  always_comb begin
    idx_d     = idx_q;
    bad_d     = bad_q;
    bc_bad_d  = bc_bad_q;
    uc_bad_d  = uc_bad_q;
    sha_d     = sha_q;
    spa_d     = spa_q;
    mism      = 1'b0;
    bc_fail   = bc_bad_q;
    uc_fail   = uc_bad_q;
    bad_now   = bad_q;
    req_valid = 1'b0;
    if (rx_tvalid) begin
      // Destination passes if it is all-broadcast or all-ours; track both alternatives.
      for (int k = 0; k < 6; k++) begin
        if (idx_q == 6'(OFF_DST + k)) begin
          if (rx_tdata != 8'hFF) bc_fail = 1'b1;
          if (rx_tdata != my_mac[47-8*k -: 8]) uc_fail = 1'b1;
        end
      end
      if (idx_q >= 6'(OFF_TYPE) && idx_q < 6'(OFF_SHA) && rx_tdata != hdr_byte(idx_q, OPER_REQ))
        mism = 1'b1;
      for (int k = 0; k < 4; k++) begin
        if (idx_q == 6'(OFF_TPA + k) && rx_tdata != my_ip[31-8*k -: 8]) mism = 1'b1;
        if (idx_q == 6'(OFF_SPA + k)) spa_d[31-8*k -: 8] = rx_tdata;
      end
      for (int k = 0; k < 6; k++) begin
        if (idx_q == 6'(OFF_SHA + k)) sha_d[47-8*k -: 8] = rx_tdata;
      end
      bad_now   = bad_q | mism | (bc_fail & uc_fail);
      req_valid = rx_tlast && !bad_now && (idx_q >= 6'(OFF_TPA + 3));
      if (rx_tlast) begin
        idx_d    = '0;
        bad_d    = 1'b0;
        bc_bad_d = 1'b0;
        uc_bad_d = 1'b0;
      end else begin
        idx_d    = (idx_q == 6'd63) ? idx_q : idx_q + 6'd1;
        bad_d    = bad_now;
        bc_bad_d = bc_fail;
        uc_bad_d = uc_fail;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q    <= '0;
      bad_q    <= 1'b0;
      bc_bad_q <= 1'b0;
      uc_bad_q <= 1'b0;
      sha_q    <= '0;
      spa_q    <= '0;
    end else begin
      idx_q    <= idx_d;
      bad_q    <= bad_d;
      bc_bad_q <= bc_bad_d;
      uc_bad_q <= uc_bad_d;
      sha_q    <= sha_d;
      spa_q    <= spa_d;
    end
  end

  assign req_sha = sha_q;
  assign req_spa = spa_q;

endmodule

// File: rtl/arp_responder.sv
// ARP responder: parses RX requests for MYIPADDR and sends a TX_LEN-byte reply starting the cycle after rx tlast.
// TX holds data/last while tx_tready is low; requests arriving while a reply is in flight are dropped and counted.
module arp_responder
  import arp_pkg::*;
#(
  parameter int COUNT_W = 16,
  parameter int TX_LEN  = 60
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        MYIPADDR_i,
  input  logic [47:0]        MYMACADDR_i,
  arp_responder_if.slave     bus,
  output logic [COUNT_W-1:0] reply_count,
  output logic [COUNT_W-1:0] busy_drop_count
);

  localparam logic [5:0] LAST = 6'(TX_LEN - 1);

  logic        req_valid;
  logic [47:0] req_sha;
  logic [31:0] req_spa;

  arp_rx_parser u_rx (
    .clk      (clk),
    .reset    (reset),
    .my_ip    (MYIPADDR_i),
    .my_mac   (MYMACADDR_i),
    .rx_tdata (bus.rx_tdata),
    .rx_tvalid(bus.rx_tvalid),
    .rx_tlast (bus.rx_tlast),
    .req_valid(req_valid),
    .req_sha  (req_sha),
    .req_spa  (req_spa)
  );

  tx_state_t           state_q, state_d;
  logic [5:0]          tcnt_q, tcnt_d;
  logic [47:0]         rsha_q, rsha_d, rmac_q, rmac_d;
  logic [31:0]         rspa_q, rspa_d, rip_q, rip_d;
  logic [COUNT_W-1:0]  reply_count_q, reply_count_d;
  logic [COUNT_W-1:0]  drop_count_q, drop_count_d;
  logic [7:0]          tx_byte;

  always_comb begin
    state_d       = state_q;
    tcnt_d        = tcnt_q;
    rsha_d        = rsha_q;
    rspa_d        = rspa_q;
    rip_d         = rip_q;
    rmac_d        = rmac_q;
    reply_count_d = reply_count_q;
    drop_count_d  = drop_count_q;
    unique case (state_q)
      TX_IDLE: begin
        // Identity is latched here so later config writes cannot corrupt this reply.
        if (req_valid) begin
          state_d = TX_SEND;
          tcnt_d  = '0;
          rsha_d  = req_sha;
          rspa_d  = req_spa;
          rip_d   = MYIPADDR_i;
          rmac_d  = MYMACADDR_i;
        end
      end
      TX_SEND: begin
        if (req_valid) drop_count_d = drop_count_q + COUNT_W'(1);
        if (bus.tx_tready) begin
          if (tcnt_q == LAST) begin
            state_d       = TX_IDLE;
            tcnt_d        = '0;
            reply_count_d = reply_count_q + COUNT_W'(1);
          end else begin
            tcnt_d = tcnt_q + 6'd1;
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    tx_byte = 8'h00;
    for (int k = 0; k < 6; k++) begin
      if (tcnt_q == 6'(OFF_DST + k)) tx_byte = rsha_q[47-8*k -: 8];
      if (tcnt_q == 6'(OFF_SRC + k)) tx_byte = rmac_q[47-8*k -: 8];
      if (tcnt_q == 6'(OFF_SHA + k)) tx_byte = rmac_q[47-8*k -: 8];
      if (tcnt_q == 6'(OFF_THA + k)) tx_byte = rsha_q[47-8*k -: 8];
    end
    for (int k = 0; k < 4; k++) begin
      if (tcnt_q == 6'(OFF_SPA + k)) tx_byte = rip_q[31-8*k -: 8];
      if (tcnt_q == 6'(OFF_TPA + k)) tx_byte = rspa_q[31-8*k -: 8];
    end
    if (tcnt_q >= 6'(OFF_TYPE) && tcnt_q < 6'(OFF_SHA)) tx_byte = hdr_byte(tcnt_q, OPER_REP);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= TX_IDLE;
      tcnt_q        <= '0;
      rsha_q        <= '0;
      rspa_q        <= '0;
      rip_q         <= '0;
      rmac_q        <= '0;
      reply_count_q <= '0;
      drop_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      tcnt_q        <= tcnt_d;
      rsha_q        <= rsha_d;
      rspa_q        <= rspa_d;
      rip_q         <= rip_d;
      rmac_q        <= rmac_d;
      reply_count_q <= reply_count_d;
      drop_count_q  <= drop_count_d;
    end
  end

  assign bus.tx_tvalid   = (state_q == TX_SEND);
  assign bus.tx_tdata    = bus.tx_tvalid ? tx_byte : 8'h00;
  assign bus.tx_tlast    = bus.tx_tvalid && (tcnt_q == LAST);
  assign reply_count     = reply_count_q;
  assign busy_drop_count = drop_count_q;

endmodule
